// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter owning a shared 4:1 data mux, with a hold limit.
// Ports: clk, rst_n, req[3:0], a/b/c/d[DW], grant[3:0], s1, s0, busy, y[DW].
module rr_mux_arbiter_4 #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [3:0]    grant,
    output logic          s1,
    output logic          s0,
    output logic          busy,
    output logic [DW-1:0] y
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [3:0]    grant_q, grant_d;
    logic [3:0]    others;
    logic [1:0]    win;

    // First set bit of r scanning from ptr+1, wrapping; ptr itself is last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign others = req & ~(4'b0001 << owner_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        win     = owner_q;
        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    win     = rr_pick(req, last_q);
                    state_d = GRANT;
                    owner_d = win;
                    hold_d  = '0;
                    grant_d = 4'b0001 << win;
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    if (hold_q < HOLD_MAX) begin
                        // Counts while alone too, but saturates harmlessly.
                        hold_d = hold_q + 1'b1;
                    end else if (others != 4'b0000) begin
                        win     = rr_pick(others, owner_q);
                        owner_d = win;
                        last_d  = owner_q;
                        hold_d  = '0;
                        grant_d = 4'b0001 << win;
                    end
                end else if (others != 4'b0000) begin
                    win     = rr_pick(others, owner_q);
                    owner_d = win;
                    last_d  = owner_q;
                    hold_d  = '0;
                    grant_d = 4'b0001 << win;
                end else begin
                    // Selects keep their value; y is gated by busy.
                    state_d = IDLE;
                    last_d  = owner_q;
                    hold_d  = '0;
                    grant_d = 4'b0000;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= '0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;
    assign s1    = owner_q[1];
    assign s0    = owner_q[0];
    assign busy  = (state_q == GRANT);

    always_comb begin
        y = '0;
        if (busy) begin
            unique case (owner_q)
                2'd0:    y = a;
                2'd1:    y = b;
                2'd2:    y = c;
                default: y = d;
            endcase
        end
    end

endmodule
